datapath_sequencer: RTL and testbench

- Hardwired control unit for the single-bus Mini SRC datapath.
- Steps the fetch/decode/execute micro-cycles for register and immediate ALU instructions, mul/div, nop and halt.
- Drives every bus-source strobe, register-load strobe, the 5-bit ALU CONTROL code, IncPC and the memory Read handshake.
- Sits beside the datapath. It reads the IR contents and returns control strobes in the same cycle-level form the datapath consumes.

---
 rtl/datapath_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Hardwired micro-sequencer for the single-bus Mini SRC datapath: fetch, decode
// and execute of register/immediate ALU ops, mul/div, neg/not, nop and halt.
module datapath_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int ADDR_W      = 4
) (
  input  logic                     Clock,
  input  logic                     Clear,
  input  logic                     Run,
  input  logic [31:0]              IR_Data,
  input  logic                     Mem_Ready,
  output logic                     PC_Out,
  output logic                     MDR_Out,
  output logic                     ZHI_Out,
  output logic                     ZLO_Out,
  output logic                     HI_Out,
  output logic                     LO_Out,
  output logic                     C_Out,
  output logic                     PC_In,
  output logic                     MDR_In,
  output logic                     MAR_In,
  output logic                     IR_In,
  output logic                     Y_In,
  output logic                     ZHI_In,
  output logic                     ZLO_In,
  output logic                     HI_In,
  output logic                     LO_In,
  output logic [(2**ADDR_W)-1:0]   R_Out,
  output logic [(2**ADDR_W)-1:0]   R_In,
  output logic [4:0]               CONTROL,
  output logic                     IncPC,
  output logic                     Read,
  output logic                     Halted,
  output logic                     Fault
);

  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T5M, S_T6M, S_HALT
  } state_t;

  typedef struct packed {
    logic            pc_out;
    logic            mdr_out;
    logic            zhi_out;
    logic            zlo_out;
    logic            hi_out;
    logic            lo_out;
    logic            c_out;
    logic            pc_in;
    logic            mar_in;
    logic            ir_in;
    logic            y_in;
    logic            zhi_in;
    logic            zlo_in;
    logic            hi_in;
    logic            lo_in;
    logic [NREG-1:0] r_out;
    logic [NREG-1:0] r_in;
    logic [4:0]      control;
    logic            inc_pc;
    logic            read;
    logic            halted;
  } ctrl_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  ctrl_t              ctrl_q, ctrl_d;

  logic [4:0]         opcode_s;
  logic [ADDR_W-1:0]  ra_s, rb_s, rc_s;
  logic               is_reg_s, is_imm_s, is_md_s, is_un_s;
  logic [4:0]         alu_code_s;
  logic               unused_ir_s;

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NREG-1:0] v;
    v = {{(NREG-1){1'b0}}, 1'b1};
    return v << idx;
  endfunction

  assign opcode_s    = IR_Data[31:27];
  assign ra_s        = IR_Data[26 -: ADDR_W];
  assign rb_s        = IR_Data[22 -: ADDR_W];
  assign rc_s        = IR_Data[18 -: ADDR_W];
  assign unused_ir_s = ^IR_Data[14:0];

  assign is_reg_s = (opcode_s >= OP_ADD) && (opcode_s <= OP_ROL);
  assign is_imm_s = (opcode_s >= OP_ADDI) && (opcode_s <= OP_ORI);
  assign is_md_s  = (opcode_s == OP_MUL) || (opcode_s == OP_DIV);
  assign is_un_s  = (opcode_s == OP_NEG) || (opcode_s == OP_NOT);

  // Immediate forms reuse the ALU code of their register counterpart.
  always_comb begin
    case (opcode_s)
      OP_ADDI: alu_code_s = OP_ADD;
      OP_ANDI: alu_code_s = OP_AND;
      OP_ORI:  alu_code_s = OP_OR;
      default: alu_code_s = opcode_s;
    endcase
  end

  // Next state, memory-wait counter, sticky fault and next-cycle strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = {CNT_W{1'b0}};
    fault_d = fault_q;
    ctrl_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_T0;
        else     state_d = S_IDLE;
      end
      S_T0: state_d = S_T1;
      S_T1: begin
        if (Mem_Ready) begin
          state_d = S_T2;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_T2: state_d = S_DEC;
      S_DEC: begin
        if (is_reg_s || is_imm_s || is_md_s) begin
          state_d = S_T3;
        end else if (is_un_s) begin
          state_d = S_T4;
        end else if (opcode_s == OP_NOP) begin
          state_d = S_IDLE;
        end else if (opcode_s == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_IDLE;
          fault_d = 1'b1;
        end
      end
      S_T3: state_d = S_T4;
      S_T4: begin
        if (is_md_s) state_d = S_T5M;
        else         state_d = S_T5;
      end
      S_T5:   state_d = S_IDLE;
      S_T5M:  state_d = S_T6M;
      S_T6M:  state_d = S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the state being entered so they register cleanly.
    case (state_d)
      S_T0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.inc_pc = 1'b1;
      end
      S_T1: ctrl_d.read = 1'b1;
      S_T2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      S_T3: begin
        ctrl_d.r_out = onehot(rb_s);
        ctrl_d.y_in  = 1'b1;
      end
      S_T4: begin
        ctrl_d.zhi_in  = 1'b1;
        ctrl_d.zlo_in  = 1'b1;
        ctrl_d.control = alu_code_s;
        if (is_imm_s) begin
          ctrl_d.c_out = 1'b1;
        end else if (is_un_s) begin
          ctrl_d.r_out = onehot(rb_s);
        end else begin
          ctrl_d.r_out = onehot(rc_s);
        end
      end
      S_T5: begin
        ctrl_d.zlo_out = 1'b1;
        ctrl_d.r_in    = onehot(ra_s);
      end
      S_T5M: begin
        ctrl_d.zlo_out = 1'b1;
        ctrl_d.lo_in   = 1'b1;
      end
      S_T6M: begin
        ctrl_d.zhi_out = 1'b1;
        ctrl_d.hi_in   = 1'b1;
      end
      S_HALT: ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  // State, counter, fault and output registers.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      fault_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign PC_Out  = ctrl_q.pc_out;
  assign MDR_Out = ctrl_q.mdr_out;
  assign ZHI_Out = ctrl_q.zhi_out;
  assign ZLO_Out = ctrl_q.zlo_out;
  assign HI_Out  = ctrl_q.hi_out;
  assign LO_Out  = ctrl_q.lo_out;
  assign C_Out   = ctrl_q.c_out;
  assign PC_In   = ctrl_q.pc_in;
  assign MAR_In  = ctrl_q.mar_in;
  assign IR_In   = ctrl_q.ir_in;
  assign Y_In    = ctrl_q.y_in;
  assign ZHI_In  = ctrl_q.zhi_in;
  assign ZLO_In  = ctrl_q.zlo_in;
  assign HI_In   = ctrl_q.hi_in;
  assign LO_In   = ctrl_q.lo_in;
  assign R_Out   = ctrl_q.r_out;
  assign R_In    = ctrl_q.r_in;
  assign CONTROL = ctrl_q.control;
  assign IncPC   = ctrl_q.inc_pc;
  assign Read    = ctrl_q.read;
  assign Halted  = ctrl_q.halted;
  assign Fault   = fault_q;
  // MDR loads in the same T1 cycle the memory reports data valid.
  assign MDR_In  = ctrl_q.read & Mem_Ready;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized self-checking bench for datapath_sequencer; expected strobe traces
// are generated per instruction from the micro-cycle rules of the Mini SRC.
module tb_datapath_sequencer;

  localparam int TMO = 15;

  typedef struct packed {
    logic        pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, c_out;
    logic        pc_in, mdr_in, mar_in, ir_in, y_in, zhi_in, zlo_in, hi_in, lo_in;
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic [4:0]  control;
    logic        inc_pc, read, halted, fault;
  } outs_t;

  logic        clk = 1'b0;
  logic        clear;
  logic        Run;
  logic [31:0] IR_Data;
  logic        Mem_Ready;
  logic        PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out;
  logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In;
  logic [15:0] R_Out, R_In;
  logic [4:0]  CONTROL;
  logic        IncPC, Read, Halted, Fault;

  int    checks = 0;
  int    failures = 0;
  outs_t exp_q[$];
  int    idle_start;
  bit    model_fault;

  datapath_sequencer #(.MEM_TIMEOUT(TMO), .ADDR_W(4)) dut (
    .Clock(clk), .Clear(clear), .Run(Run), .IR_Data(IR_Data), .Mem_Ready(Mem_Ready),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZHI_Out(ZHI_Out), .ZLO_Out(ZLO_Out),
    .HI_Out(HI_Out), .LO_Out(LO_Out), .C_Out(C_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
    .ZHI_In(ZHI_In), .ZLO_In(ZLO_In), .HI_In(HI_In), .LO_In(LO_In),
    .R_Out(R_Out), .R_In(R_In), .CONTROL(CONTROL), .IncPC(IncPC), .Read(Read),
    .Halted(Halted), .Fault(Fault)
  );

  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t o;
    o.pc_out = PC_Out;  o.mdr_out = MDR_Out; o.zhi_out = ZHI_Out; o.zlo_out = ZLO_Out;
    o.hi_out = HI_Out;  o.lo_out = LO_Out;   o.c_out = C_Out;
    o.pc_in = PC_In;    o.mdr_in = MDR_In;   o.mar_in = MAR_In;   o.ir_in = IR_In;
    o.y_in = Y_In;      o.zhi_in = ZHI_In;   o.zlo_in = ZLO_In;   o.hi_in = HI_In;
    o.lo_in = LO_In;    o.r_out = R_Out;     o.r_in = R_In;       o.control = CONTROL;
    o.inc_pc = IncPC;   o.read = Read;       o.halted = Halted;   o.fault = Fault;
    return o;
  endfunction

  function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc, input int c);
    logic [31:0] v;
    v = {5'(op), 4'(ra), 4'(rb), 19'(c)};
    v[18:15] = 4'(rc);
    return v;
  endfunction

  // At most one bus source may drive the bus in any cycle.
  always @(negedge clk) begin
    int n;
    n = $countones({PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, R_Out});
    checks++;
    if (n > 1) begin
      failures++;
      $display("FAIL bus_onehot t=%0t sources=%0d required<=1", $time, n);
    end
  end

  task automatic push_c(input outs_t o);
    o.fault = model_fault;
    exp_q.push_back(o);
  endtask

  // Expected per-cycle trace for one instruction from IDLE through its return to IDLE.
  task automatic build(input logic [31:0] ir, input int waits, input int halt_cycles, input int extra_idle);
    outs_t o;
    int op, ra, rb, rc;
    bit reg_f, imm_f, md_f, un_f;
    logic [15:0] one;
    one = 16'h0001;
    op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    reg_f = (op >= 3) && (op <= 11);
    imm_f = (op >= 12) && (op <= 14);
    md_f  = (op == 15) || (op == 16);
    un_f  = (op == 17) || (op == 18);
    o = '0; o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; push_c(o);
    for (int w = 0; w < waits && w < TMO; w++) begin
      o = '0; o.read = 1'b1; push_c(o);
    end
    if (waits >= TMO) begin
      model_fault = 1'b1;
      for (int h = 0; h < halt_cycles; h++) begin o = '0; o.halted = 1'b1; push_c(o); end
      idle_start = exp_q.size();
      return;
    end
    o = '0; o.read = 1'b1; o.mdr_in = 1'b1; push_c(o);
    o = '0; o.mdr_out = 1'b1; o.ir_in = 1'b1; push_c(o);
    o = '0; push_c(o);
    if (op == 27) begin
      for (int h = 0; h < halt_cycles; h++) begin o = '0; o.halted = 1'b1; push_c(o); end
      idle_start = exp_q.size();
      return;
    end
    if (reg_f || imm_f || md_f) begin
      o = '0; o.r_out = one << rb; o.y_in = 1'b1; push_c(o);
    end
    if (reg_f || imm_f || md_f || un_f) begin
      o = '0; o.zhi_in = 1'b1; o.zlo_in = 1'b1;
      if (imm_f) begin
        o.control = (op == 12) ? 5'd3 : ((op == 13) ? 5'd5 : 5'd6);
        o.c_out = 1'b1;
      end else begin
        o.control = 5'(op);
        o.r_out = un_f ? (one << rb) : (one << rc);
      end
      push_c(o);
      if (md_f) begin
        o = '0; o.zlo_out = 1'b1; o.lo_in = 1'b1; push_c(o);
        o = '0; o.zhi_out = 1'b1; o.hi_in = 1'b1; push_c(o);
      end else begin
        o = '0; o.zlo_out = 1'b1; o.r_in = one << ra; push_c(o);
      end
    end else if (op != 26) begin
      model_fault = 1'b1;
    end
    idle_start = exp_q.size();
    for (int k = 0; k <= extra_idle; k++) begin o = '0; push_c(o); end
  endtask

  task automatic exec(input logic [31:0] ir, input int waits, input bit rand_run,
                      input int extra_idle, input int halt_cycles, input string name);
    outs_t got;
    int last;
    IR_Data = ir;
    exp_q.delete();
    build(ir, waits, halt_cycles, extra_idle);
    last = exp_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      @(posedge clk); #1;
      if (i >= 1 && i <= waits) Mem_Ready = 1'b0;
      else if (i == waits + 1)  Mem_Ready = 1'b1;
      else                      Mem_Ready = 1'($urandom_range(0, 1));
      if (i == last)            Run = 1'b1;
      else if (i >= idle_start) Run = 1'b0;
      else if (rand_run)        Run = 1'($urandom_range(0, 1));
      else                      Run = 1'b1;
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL %s cyc%0d got=%h exp=%h", name, i, got, exp_q[i]);
      end
    end
    Run = 1'b1;
  endtask

  task automatic do_clear(input int cycles, input string name);
    outs_t got;
    clear = 1'b0;
    model_fault = 1'b0;
    #1;
    for (int c = 0; c <= cycles; c++) begin
      IR_Data = $urandom; Run = 1'($urandom_range(0, 1)); Mem_Ready = 1'($urandom_range(0, 1));
      if (c > 0) @(negedge clk);
      else #1;
      got = sample();
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL %s clr%0d got=%h exp=0", name, c, got);
      end
    end
    Run = 1'b1;
    Mem_Ready = 1'b0;
    clear = 1'b1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    @(negedge clk);
    do_clear(2, "reset");
  endtask

  task automatic test_alu_forms();
    exec(32'h1A92_0000, 0, 1'b0, 0, 0, "add_r5_r2_r4");
    exec(mk(12, 3, 1, 0, 19'h25), 0, 1'b0, 0, 0, "addi_r3_r1");
    exec(mk(15, 0, 6, 7, 0), 0, 1'b0, 0, 0, "mul_r6_r7");
    exec(mk(16, 9, 9, 9, 0), 1, 1'b0, 0, 0, "div_same_regs");
    exec(mk(17, 2, 11, 0, 0), 0, 1'b0, 0, 0, "neg");
    exec(mk(18, 15, 0, 0, 0), 2, 1'b0, 0, 0, "not");
    exec(mk(13, 4, 8, 0, 19'h7FFFF), 0, 1'b0, 0, 0, "andi");
    exec(mk(14, 0, 15, 0, 19'h1), 0, 1'b0, 0, 0, "ori");
    exec(mk(26, 0, 0, 0, 0), 0, 1'b0, 0, 0, "nop");
  endtask

  task automatic test_mem_wait();
    exec(mk(4, 1, 2, 3, 0), 3, 1'b0, 0, 0, "wait3_sub");
  endtask

  task automatic test_illegal();
    exec(mk(31, 1, 2, 3, 0), 0, 1'b0, 0, 0, "illegal_11111");
    exec(mk(7, 6, 5, 4, 0), 0, 1'b0, 0, 0, "after_fault_shr");
  endtask

  task automatic test_run_drop();
    exec(mk(9, 10, 3, 12, 0), 1, 1'b1, 4, 0, "run_drop_shl");
  endtask

  task automatic test_clear_mid();
    outs_t got;
    IR_Data = 32'h1A92_0000;
    exp_q.delete();
    build(32'h1A92_0000, 0, 0, 0);
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      Mem_Ready = (i == 1); Run = 1'b1;
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL clear_mid cyc%0d got=%h exp=%h", i, got, exp_q[i]);
      end
    end
    #2;
    do_clear(1, "clear_in_t4");
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 25; n++) begin
      op = $urandom_range(0, 31);
      if (op == 27) op = 26;
      exec(mk(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 19'h7FFFF)), $urandom_range(0, 3), 1'b1, 0, 0, "random");
    end
  endtask

  task automatic test_halt();
    exec(mk(27, 0, 0, 0, 0), 1, 1'b1, 0, 8, "halt_run_toggle");
    do_clear(1, "clear_after_halt");
  endtask

  task automatic test_timeout();
    exec(mk(3, 1, 1, 1, 0), TMO, 1'b0, 0, 3, "mem_timeout");
    do_clear(1, "clear_after_timeout");
    exec(mk(5, 7, 2, 3, 0), 0, 1'b0, 0, 0, "after_timeout_and");
  endtask

  initial begin
    clear = 1'b0; Run = 1'b0; IR_Data = 32'h0; Mem_Ready = 1'b0;
    model_fault = 1'b0; idle_start = 0;
    test_reset();
    test_alu_forms();
    test_mem_wait();
    test_illegal();
    test_run_drop();
    test_clear_mid();
    test_random();
    test_halt();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
